// File: rtl/cnn_window_gen.sv
// Streaming 3x3 window generator: two row line buffers plus a two-column history.
// Define ZERO_PAD_EN for zero-padded "same" output; the default build emits "valid" windows only.
module cnn_window_gen #(
    parameter int DW    = 8,
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int AW    = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3*DW-1:0] win_top,
    output logic [3*DW-1:0] win_mid,
    output logic [3*DW-1:0] win_bot,
    output logic [AW-1:0]   out_row,
    output logic [AW-1:0]   out_col,
    output logic            frame_done,
    output logic [1:0]      dbg_state
);
    // Handshakes: a transfer happens on a rising edge where valid && ready; a producer
    // holds valid and data stable until ready, and ready never depends on valid.
    typedef enum logic [1:0] {RUN = 2'd0, EOL = 2'd1, FLUSH = 2'd2, DONE = 2'd3} state_t;

    localparam int PW = 3 * DW;
    localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 2;
    localparam logic [AW-1:0] COL_LAST = AW'(IMG_W - 1);
    localparam logic [AW-1:0] ROW_LAST = AW'(IMG_H - 1);
`ifdef ZERO_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    state_t state, state_nxt;
    logic [DW-1:0] lb0 [IMG_W];
    logic [DW-1:0] lb1 [IMG_W];
    // Columns are packed {top, mid, bot}; col_a is two columns back, col_b one column back.
    logic [PW-1:0] col_a, col_b, new_col, c_l, c_c, c_r;
    logic [AW-1:0] in_col, in_row, cur_r, fcol, g_row, g_col;
    logic [CW-1:0] c_idx, f_idx, fl_idx, fr_idx;
    logic          out_free, hs, gen, zero_top, zero_left, last_px;

    assign c_idx     = in_col[CW-1:0];
    assign f_idx     = fcol[CW-1:0];
    assign fl_idx    = (fcol == '0) ? f_idx : f_idx - CW'(1);
    assign fr_idx    = (fcol == COL_LAST) ? f_idx : f_idx + CW'(1);
    assign last_px   = (in_row == ROW_LAST) && (in_col == COL_LAST);
    assign dbg_state = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= RUN;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            RUN: begin
                if (hs) begin
                    if (PAD && in_col == COL_LAST) state_nxt = EOL;
                    else if (!PAD && last_px)      state_nxt = DONE;
                end
            end
            // The final row's end-of-line window precedes the flush of the last image row.
            EOL: begin
                if (cur_r == '0)  state_nxt = RUN;
                else if (out_free) state_nxt = (cur_r == ROW_LAST) ? FLUSH : RUN;
            end
            FLUSH: if (out_free && fcol == COL_LAST) state_nxt = DONE;
            DONE:  if (out_valid && out_ready) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    always_comb begin
        out_free  = !out_valid || out_ready;
        in_ready  = reset && (state == RUN) && out_free;
        hs        = in_valid && in_ready;
        new_col   = {lb1[c_idx], lb0[c_idx], in_data};
        gen       = 1'b0;
        zero_top  = 1'b0;
        zero_left = 1'b0;
        g_row     = '0;
        g_col     = '0;
        c_l       = col_a;
        c_c       = col_b;
        c_r       = new_col;
        unique case (state)
            RUN: begin
                g_row = in_row - AW'(1);
                g_col = in_col - AW'(1);
                if (PAD) begin
                    gen       = hs && (in_row != '0) && (in_col != '0);
                    zero_top  = (in_row == AW'(1));
                    zero_left = (in_col == AW'(1));
                end else begin
                    gen = hs && (in_row > AW'(1)) && (in_col > AW'(1));
                end
            end
            EOL: begin
                c_r      = '0;
                g_row    = cur_r - AW'(1);
                g_col    = COL_LAST;
                zero_top = (cur_r == AW'(1));
                gen      = out_free && (cur_r != '0);
            end
            FLUSH: begin
                c_l   = (fcol == '0) ? '0 : {lb1[fl_idx], lb0[fl_idx], {DW{1'b0}}};
                c_c   = {lb1[f_idx], lb0[f_idx], {DW{1'b0}}};
                c_r   = (fcol == COL_LAST) ? '0 : {lb1[fr_idx], lb0[fr_idx], {DW{1'b0}}};
                g_row = ROW_LAST;
                g_col = fcol;
                gen   = out_free;
            end
            default: ;
        endcase
        if (zero_left) c_l = '0;
        if (zero_top) begin
            c_l[PW-1:2*DW] = '0;
            c_c[PW-1:2*DW] = '0;
            c_r[PW-1:2*DW] = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < IMG_W; i++) begin
                lb0[i] <= '0;
                lb1[i] <= '0;
            end
        end else if (hs) begin
            lb1[c_idx] <= lb0[c_idx];
            lb0[c_idx] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col_a      <= '0;
            col_b      <= '0;
            in_col     <= '0;
            in_row     <= '0;
            cur_r      <= '0;
            fcol       <= '0;
            out_valid  <= 1'b0;
            win_top    <= '0;
            win_mid    <= '0;
            win_bot    <= '0;
            out_row    <= '0;
            out_col    <= '0;
            frame_done <= 1'b0;
        end else begin
            if (hs) begin
                col_a <= col_b;
                col_b <= new_col;
                cur_r <= in_row;
                if (in_col == COL_LAST) begin
                    in_col <= '0;
                    in_row <= (in_row == ROW_LAST) ? '0 : in_row + AW'(1);
                end else begin
                    in_col <= in_col + AW'(1);
                end
            end
            if (state == FLUSH && out_free) fcol <= (fcol == COL_LAST) ? '0 : fcol + AW'(1);
            if (gen) begin
                out_valid <= 1'b1;
                win_top   <= {c_l[PW-1:2*DW], c_c[PW-1:2*DW], c_r[PW-1:2*DW]};
                win_mid   <= {c_l[2*DW-1:DW], c_c[2*DW-1:DW], c_r[2*DW-1:DW]};
                win_bot   <= {c_l[DW-1:0], c_c[DW-1:0], c_r[DW-1:0]};
                out_row   <= g_row;
                out_col   <= g_col;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            frame_done <= (state == DONE) && out_valid && out_ready;
        end
    end
endmodule
